// File: rtl/pipeline_pkg.sv
// Shared widths, control-bundle bit map and the ID/EX payload type for the MIPS pipeline.
package pipeline_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 16;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned REG_W  = 5;

   localparam int unsigned CTRL_REGWRITE  = 0;
   localparam int unsigned CTRL_MEMREAD   = 1;
   localparam int unsigned CTRL_MEMWRITE  = 2;
   localparam int unsigned CTRL_MEMTOREG  = 3;
   localparam int unsigned CTRL_ALUSRC    = 4;
   localparam int unsigned CTRL_REGDST    = 5;
   localparam int unsigned CTRL_ALUOP_LSB = 6;
   localparam int unsigned CTRL_ALUOP_MSB = 7;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   typedef struct packed {
      logic [DATA_W-1:0] pc_plus4;
      logic [DATA_W-1:0] read_data1;
      logic [DATA_W-1:0] read_data2;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  shamt;
      logic              uses_rt;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_payload_t;

   // An invalid slot must never carry side-effecting control bits.
   function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid, input logic [CTRL_W-1:0] ctrl);
      return valid ? ctrl : CTRL_NOP;
   endfunction

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is a source of the ID instruction.
module id_ex_hazard_detect
   import pipeline_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hazard_c
);

   // $0 is hard-wired, so a load targeting it never creates a dependency.
   assign hazard_c = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with flush, stall and load-use bubble insertion.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipeline_register
   import pipeline_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc_plus4,
   input  logic [DATA_W-1:0] id_read_data1,
   input  logic [DATA_W-1:0] id_read_data2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [REG_W-1:0]  id_shamt,
   input  logic              id_uses_rt,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc_plus4,
   output logic [DATA_W-1:0] ex_read_data1,
   output logic [DATA_W-1:0] ex_read_data2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [REG_W-1:0]  ex_shamt,
   output logic              ex_uses_rt,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              load_use_stall
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0]  bubble_count
`endif
);

   id_ex_payload_t ex_q, ex_d, id_payload;
   logic           valid_q, valid_d;
   logic           hazard;

   id_ex_hazard_detect u_hazard (
      .ex_valid   (valid_q),
      .ex_memread (ex_q.ctrl[CTRL_MEMREAD]),
      .ex_rt      (ex_q.rt),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .hazard_c   (hazard)
   );

   assign load_use_stall = hazard & ~flush;

   always_comb begin
      id_payload            = '0;
      id_payload.pc_plus4   = id_pc_plus4;
      id_payload.read_data1 = id_read_data1;
      id_payload.read_data2 = id_read_data2;
      id_payload.imm        = id_imm;
      id_payload.rs         = id_rs;
      id_payload.rt         = id_rt;
      id_payload.rd         = id_rd;
      id_payload.shamt      = id_shamt;
      id_payload.uses_rt    = id_uses_rt;
      id_payload.ctrl       = ctrl_gate(id_valid, id_ctrl);
   end

   // Priority: flush > stall > load-use bubble > capture.
   always_comb begin
      ex_d    = ex_q;
      valid_d = valid_q;
      if (flush) begin
         ex_d    = '0;
         valid_d = 1'b0;
      end else if (stall) begin
         ex_d    = ex_q;
         valid_d = valid_q;
      end else if (hazard) begin
         ex_d    = '0;
         valid_d = 1'b0;
      end else begin
         ex_d    = id_payload;
         valid_d = id_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ex_q    <= ex_d;
         valid_q <= valid_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_pc_plus4   = ex_q.pc_plus4;
   assign ex_read_data1 = ex_q.read_data1;
   assign ex_read_data2 = ex_q.read_data2;
   assign ex_imm        = ex_q.imm;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_rd         = ex_q.rd;
   assign ex_shamt      = ex_q.shamt;
   assign ex_uses_rt    = ex_q.uses_rt;
   assign ex_ctrl       = ex_q.ctrl;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic bubble;
   assign bubble = load_use_stall & ~stall;

   // Saturating count of inserted load-use bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_count <= '0;
      end else if (bubble && (bubble_count != '1)) begin
         bubble_count <= bubble_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register (scoreboard of expected EX state).
module tb_id_ex_pipeline_register;

   logic        clk, rst, stall, flush, id_valid, id_uses_rt;
   logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_ctrl;
   logic        ex_valid, ex_uses_rt, load_use_stall;
   logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [15:0] ex_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count;
`endif

   id_ex_pipeline_register dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc_plus4(id_pc_plus4), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
      .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1),
      .ex_read_data2(ex_read_data2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_uses_rt(ex_uses_rt), .ex_ctrl(ex_ctrl),
      .load_use_stall(load_use_stall)
`ifdef ID_EX_BUBBLE_CNT_EN
      , .bubble_count(bubble_count)
`endif
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd, shamt;
      logic        uses_rt;
      logic [15:0] ctrl;
   } mstate_t;

   typedef struct {
      mstate_t     st;
      logic [31:0] cnt;
   } exp_t;

   mstate_t     m;
   logic [31:0] m_cnt;
   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input exp_t e);
      chk({tag, ".valid"},   32'(ex_valid),      32'(e.st.valid));
      chk({tag, ".pc"},      ex_pc_plus4,        e.st.pc);
      chk({tag, ".rd1"},     ex_read_data1,      e.st.rd1);
      chk({tag, ".rd2"},     ex_read_data2,      e.st.rd2);
      chk({tag, ".imm"},     ex_imm,             e.st.imm);
      chk({tag, ".rs"},      32'(ex_rs),         32'(e.st.rs));
      chk({tag, ".rt"},      32'(ex_rt),         32'(e.st.rt));
      chk({tag, ".rd"},      32'(ex_rd),         32'(e.st.rd));
      chk({tag, ".shamt"},   32'(ex_shamt),      32'(e.st.shamt));
      chk({tag, ".uses_rt"}, 32'(ex_uses_rt),    32'(e.st.uses_rt));
      chk({tag, ".ctrl"},    32'(ex_ctrl),       32'(e.st.ctrl));
`ifdef ID_EX_BUBBLE_CNT_EN
      chk({tag, ".count"},   bubble_count,       e.cnt);
`endif
   endtask

   task automatic model_reset();
      m     = '0;
      m_cnt = '0;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic [15:0] ctrl, input logic [31:0] imm);
      id_valid      = v;
      id_rs         = rs;
      id_rt         = rt;
      id_rd         = 5'($urandom);
      id_shamt      = 5'($urandom);
      id_uses_rt    = ur;
      id_ctrl       = ctrl;
      id_imm        = imm;
      id_pc_plus4   = $urandom;
      id_read_data1 = $urandom;
      id_read_data2 = $urandom;
   endtask

   task automatic expect_lus(input string tag, input logic v);
      #1;
      chk({tag, ".lus_const"}, 32'(load_use_stall), 32'(v));
   endtask

   // Push the expected post-edge state, clock once, then pop and compare.
   task automatic drive_cycle(input string tag);
      logic    hz;
      mstate_t n;
      exp_t    e;
      #1;
      hz = m.valid & m.ctrl[1] & (m.rt != 5'd0) & id_valid &
           ((m.rt == id_rs) | (id_uses_rt & (m.rt == id_rt)));
      chk({tag, ".lus"}, 32'(load_use_stall), 32'(hz & ~flush));
      n = m;
      if (flush) begin
         n = '0;
      end else if (stall) begin
         n = m;
      end else if (hz) begin
         n = '0;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
         n.valid   = id_valid;
         n.pc      = id_pc_plus4;
         n.rd1     = id_read_data1;
         n.rd2     = id_read_data2;
         n.imm     = id_imm;
         n.rs      = id_rs;
         n.rt      = id_rt;
         n.rd      = id_rd;
         n.shamt   = id_shamt;
         n.uses_rt = id_uses_rt;
         n.ctrl    = id_valid ? id_ctrl : 16'h0000;
      end
      m = n;
      sb.push_back('{st: m, cnt: m_cnt});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_state(tag, e);
      end
   endtask

   initial begin
      exp_t z;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      model_reset();
      // Reset with random ID inputs
      set_id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 16'($urandom), $urandom);
      repeat (2) @(posedge clk);
      #1;
      z = '{st: m, cnt: m_cnt};
      check_state("reset", z);
      chk("reset.lus", 32'(load_use_stall), 32'd0);
      rst = 1'b0;

      // Sign-extended immediate capture with one-cycle latency
      set_id(1'b1, 5'd3, 5'd4, 1'b1, 16'h0041, 32'hFFFF8000);
      drive_cycle("t2");
      chk("t2.imm_const", ex_imm, 32'hFFFF8000);
      chk("t2.ctrl_const", 32'(ex_ctrl), 32'h0041);

      // lw $8 in EX, dependent add in ID -> one bubble
      set_id(1'b1, 5'd9, 5'd8, 1'b0, 16'h000B, 32'h10);
      drive_cycle("t3.lw");
      set_id(1'b1, 5'd8, 5'd10, 1'b1, 16'h0021, 32'h0);
      expect_lus("t3.haz", 1'b1);
      drive_cycle("t3.bubble");
      chk("t3.bubble_valid", 32'(ex_valid), 32'd0);
      chk("t3.bubble_ctrl", 32'(ex_ctrl), 32'd0);
      expect_lus("t3.after", 1'b0);
      drive_cycle("t3.capture");
      chk("t3.rs_const", 32'(ex_rs), 32'd8);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("t3.count_const", bubble_count, 32'd1);
`endif

      // Load to $0 never stalls
      set_id(1'b1, 5'd5, 5'd0, 1'b0, 16'h000B, 32'h4);
      drive_cycle("t4.lw0");
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 16'h0021, 32'h0);
      expect_lus("t4.nohaz", 1'b0);
      drive_cycle("t4.capture");

      // Flush beats hazard
      set_id(1'b1, 5'd9, 5'd8, 1'b0, 16'h000B, 32'h8);
      drive_cycle("t5.lw");
      set_id(1'b1, 5'd8, 5'd1, 1'b1, 16'h0021, 32'h0);
      flush = 1'b1;
      expect_lus("t5.flush", 1'b0);
      drive_cycle("t5.flushed");
      chk("t5.valid_const", 32'(ex_valid), 32'd0);
      flush = 1'b0;

      // External stall holds EX for three cycles
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 16'h0031, 32'h1234);
      drive_cycle("t6.load");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 16'h0011, $urandom);
         drive_cycle("t6.hold");
         chk("t6.imm_hold", ex_imm, 32'h1234);
      end
      stall = 1'b0;
      set_id(1'b1, 5'd6, 5'd7, 1'b0, 16'h0001, 32'h5678);
      drive_cycle("t6.release");
      chk("t6.imm_release", ex_imm, 32'h5678);

      // Stall with hazard: request held, bubble after release
      set_id(1'b1, 5'd1, 5'd12, 1'b0, 16'h000B, 32'h0);
      drive_cycle("t7.lw");
      set_id(1'b1, 5'd3, 5'd12, 1'b1, 16'h0021, 32'h0);
      stall = 1'b1;
      repeat (2) begin
         expect_lus("t7.held", 1'b1);
         drive_cycle("t7.hold");
      end
      stall = 1'b0;
      drive_cycle("t7.bubble");
      chk("t7.bubble_valid", 32'(ex_valid), 32'd0);
      drive_cycle("t7.capture");

      // Invalid ID slot captured with control forced to NOP
      set_id(1'b0, 5'd4, 5'd5, 1'b1, 16'hFFFF, 32'h9);
      drive_cycle("t8.invalid");
      chk("t8.ctrl_const", 32'(ex_ctrl), 32'd0);

      // Randomised mix of flush, stall and dependent loads
      for (int i = 0; i < 60; i++) begin
         set_id(($urandom % 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 16'($urandom), $urandom);
         flush = ($urandom % 8) == 0;
         stall = ($urandom % 5) == 0;
         drive_cycle("rand");
      end
      flush = 1'b0;
      stall = 1'b0;

      // Async reset during a stalled hazard
      set_id(1'b1, 5'd1, 5'd9, 1'b0, 16'h000B, 32'h0);
      drive_cycle("t9.lw");
      set_id(1'b1, 5'd9, 5'd2, 1'b1, 16'h0021, 32'h0);
      stall = 1'b1;
      expect_lus("t9.pre", 1'b1);
      rst = 1'b1;
      #1;
      model_reset();
      z = '{st: m, cnt: m_cnt};
      check_state("t9.async", z);
      chk("t9.lus", 32'(load_use_stall), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall = 1'b0;
      set_id(1'b1, 5'd11, 5'd13, 1'b1, 16'h0041, 32'hCAFE);
      drive_cycle("t9.resume");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
